// File: rtl/battleship_pkg.sv
// Shared types and constants for the battleship master-side turn sequencer.
package battleship_pkg;

   typedef enum logic [4:0] {
      PLACE_A = 5'd0,
      LOAD_A,
      CHK_A,
      PLACE_B,
      LOAD_B,
      CHK_B,
      TURN_A,
      FIRE_A,
      HIT_A,
      SET_A,
      TURN_B,
      FIRE_B,
      HIT_B,
      SET_B,
      OVER,
      RESTART
   } state_t;

   localparam int unsigned DISP_PLACE = 0;
   localparam int unsigned DISP_WAIT  = 1;
   localparam int unsigned DISP_FIRE  = 2;
   localparam int unsigned DISP_WIN   = 3;
   localparam int unsigned DISP_LOSE  = 4;

   localparam logic [1:0] WIN_NONE = 2'd0;
   localparam logic [1:0] WIN_A    = 2'd1;
   localparam logic [1:0] WIN_B    = 2'd2;

   // States in which the fleet-alive line is given time to settle before sampling
   function automatic logic isSettleState(input state_t s);
      return (s == CHK_A) || (s == CHK_B) || (s == SET_A) || (s == SET_B);
   endfunction

endpackage

// File: rtl/battleship_turn_ctrl_edge_pulse.sv
// Synchronous rising-edge detector: a rising level yields one registered pulse cycle.
module edge_pulse (
   input  logic clk,
   input  logic clr,
   input  logic i_level,
   output logic o_pulse
);

   logic r_prev;
   logic r_pulse;

   always_ff @(posedge clk) begin
      if (clr) begin
         r_prev  <= 1'b0;
         r_pulse <= 1'b0;
      end else begin
         r_prev  <= i_level;
         r_pulse <= i_level & ~r_prev;
      end
   end

   assign o_pulse = r_pulse;

endmodule

// File: rtl/battleship_turn_ctrl.sv
// Master-side game sequencer: placement, alternating attacks and game over for both boards.
// All strobes are Moore-decoded from the state register.
module battleship_turn_ctrl
   import battleship_pkg::*;
#(
   parameter int SETTLE_CYC = 4,
   parameter int TURN_W     = 8,
   parameter int DISP_W     = 3
) (
   input  logic              clk,
   input  logic              clr,
   input  logic              BTN1A,
   input  logic              BTN3A,
   input  logic              BTN1B,
   input  logic              BTN3B,
   input  logic              OKA,
   input  logic              OKB,
   input  logic              LivA,
   input  logic              LivB,
   output logic              LDR1A,
   output logic              LDR2A,
   output logic              LDR1B,
   output logic              LDR2B,
   output logic              STA,
   output logic              STB,
   output logic              game_clr,
   output logic [DISP_W-1:0] DispA,
   output logic [DISP_W-1:0] DispB,
   output logic [1:0]        winner,
   output logic [TURN_W-1:0] turn_cnt
);

   localparam int CNT_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
   localparam logic [CNT_W-1:0]  SETTLE_LOAD = CNT_W'(SETTLE_CYC - 1);
   localparam logic [TURN_W-1:0] TURN_MAX    = '1;

   state_t            r_state;
   state_t            w_nextState;
   logic [CNT_W-1:0]  r_settle;
   logic [TURN_W-1:0] r_turnCnt;
   logic [1:0]        r_winner;
   logic              w_pA1;
   logic              w_pA3;
   logic              w_pB1;
   logic              w_pB3;
   logic              w_settleDone;
   logic              w_abort;

   edge_pulse u_btn1a (.clk(clk), .clr(clr), .i_level(BTN1A), .o_pulse(w_pA1));
   edge_pulse u_btn3a (.clk(clk), .clr(clr), .i_level(BTN3A), .o_pulse(w_pA3));
   edge_pulse u_btn1b (.clk(clk), .clr(clr), .i_level(BTN1B), .o_pulse(w_pB1));
   edge_pulse u_btn3b (.clk(clk), .clr(clr), .i_level(BTN3B), .o_pulse(w_pB3));

   assign w_settleDone = (r_settle == '0);
   assign w_abort      = w_pA3 & w_pB3;

   always_ff @(posedge clk) begin
      if (clr) begin
         r_state <= PLACE_A;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Pulses from the player not on turn are simply never looked at in that state
   always_comb begin
      w_nextState = r_state;
      case (r_state)
         PLACE_A: if (w_pA1) w_nextState = LOAD_A;
         LOAD_A:  w_nextState = CHK_A;
         CHK_A:   if (w_settleDone) w_nextState = LivA ? PLACE_B : PLACE_A;
         PLACE_B: if (w_pB1) w_nextState = LOAD_B;
         LOAD_B:  w_nextState = CHK_B;
         CHK_B:   if (w_settleDone) w_nextState = LivB ? TURN_A : PLACE_B;
         TURN_A:  if (w_pA1 && OKB) w_nextState = FIRE_A;
         FIRE_A:  w_nextState = HIT_A;
         HIT_A:   w_nextState = SET_A;
         SET_A:   if (w_settleDone) w_nextState = LivB ? TURN_B : OVER;
         TURN_B:  if (w_pB1 && OKA) w_nextState = FIRE_B;
         FIRE_B:  w_nextState = HIT_B;
         HIT_B:   w_nextState = SET_B;
         SET_B:   if (w_settleDone) w_nextState = LivA ? TURN_A : OVER;
         OVER:    if (w_pA3 || w_pB3) w_nextState = RESTART;
         RESTART: w_nextState = PLACE_A;
         default: w_nextState = PLACE_A;
      endcase
      if (w_abort) w_nextState = RESTART;
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         r_settle <= '0;
      end else if (isSettleState(w_nextState) && !isSettleState(r_state)) begin
         r_settle <= SETTLE_LOAD;
      end else if (!w_settleDone) begin
         r_settle <= r_settle - CNT_W'(1);
      end
   end

   // An abort landing on the settle-done cycle must not leave a stale winner visible in RESTART
   always_ff @(posedge clk) begin
      if (clr) begin
         r_winner  <= WIN_NONE;
         r_turnCnt <= '0;
      end else if (r_state == RESTART) begin
         r_winner  <= WIN_NONE;
         r_turnCnt <= '0;
      end else if (w_settleDone && !w_abort && (r_state == SET_A || r_state == SET_B)) begin
         if ((r_state == SET_A) ? !LivB : !LivA) begin
            r_winner <= (r_state == SET_A) ? WIN_A : WIN_B;
         end else if (r_turnCnt != TURN_MAX) begin
            r_turnCnt <= r_turnCnt + TURN_W'(1);
         end
      end
   end

   always_comb begin
      LDR1A    = 1'b0;
      LDR2A    = 1'b0;
      LDR1B    = 1'b0;
      LDR2B    = 1'b0;
      STA      = 1'b0;
      STB      = 1'b0;
      DispA    = DISP_W'(DISP_PLACE);
      DispB    = DISP_W'(DISP_WAIT);
      game_clr = clr || (r_state == RESTART);
      case (r_state)
         LOAD_A: LDR1A = 1'b1;
         PLACE_B, CHK_B: begin
            DispA = DISP_W'(DISP_WAIT);
            DispB = DISP_W'(DISP_PLACE);
         end
         LOAD_B: begin
            DispA = DISP_W'(DISP_WAIT);
            DispB = DISP_W'(DISP_PLACE);
            LDR1B = 1'b1;
         end
         TURN_A, SET_A: DispA = DISP_W'(DISP_FIRE);
         FIRE_A: begin
            DispA = DISP_W'(DISP_FIRE);
            LDR2A = 1'b1;
         end
         HIT_A: begin
            DispA = DISP_W'(DISP_FIRE);
            LDR1B = 1'b1;
            STB   = 1'b1;
         end
         TURN_B, SET_B: begin
            DispA = DISP_W'(DISP_WAIT);
            DispB = DISP_W'(DISP_FIRE);
         end
         FIRE_B: begin
            DispA = DISP_W'(DISP_WAIT);
            DispB = DISP_W'(DISP_FIRE);
            LDR2B = 1'b1;
         end
         HIT_B: begin
            DispA = DISP_W'(DISP_WAIT);
            DispB = DISP_W'(DISP_FIRE);
            LDR1A = 1'b1;
            STA   = 1'b1;
         end
         OVER: begin
            DispA = (r_winner == WIN_B) ? DISP_W'(DISP_LOSE) : DISP_W'(DISP_WIN);
            DispB = (r_winner == WIN_B) ? DISP_W'(DISP_WIN) : DISP_W'(DISP_LOSE);
         end
         default: ;
      endcase
   end

   assign winner   = r_winner;
   assign turn_cnt = r_turnCnt;

endmodule

// File: tb/tb_battleship_turn_ctrl.sv
// Bench for battleship_turn_ctrl: directed game scenarios followed by randomly played games,
// checked against a game-level model of fleets, turn owner, winner and completed turns.
module tb_battleship_turn_ctrl;

   localparam int S = 4;

   logic clk = 1'b0;
   logic clr, BTN1A, BTN3A, BTN1B, BTN3B, OKA, OKB, LivA, LivB;

   logic       LDR1A, LDR2A, LDR1B, LDR2B, STA, STB, game_clr;
   logic [2:0] DispA, DispB;
   logic [1:0] winner;
   logic [7:0] turn_cnt;

   logic       LDR1A2, LDR2A2, LDR1B2, LDR2B2, STA2, STB2, game_clr2;
   logic [2:0] DispA2, DispB2;
   logic [1:0] winner2;
   logic [1:0] turn_cnt2;

   logic [5:0] strobes, strobes2;
   assign strobes  = {LDR1A, LDR2A, LDR1B, LDR2B, STA, STB};
   assign strobes2 = {LDR1A2, LDR2A2, LDR1B2, LDR2B2, STA2, STB2};

   int checks = 0;
   int errors = 0;

   // Game-level model: phase 0 place A, 1 place B, 2 playing, 3 over
   int mPhase;
   bit mTurnA;
   int mWinner;
   int mTurns;
   int fleetA;
   int fleetB;

   battleship_turn_ctrl #(.SETTLE_CYC(S), .TURN_W(8), .DISP_W(3)) dut (
      .clk(clk), .clr(clr), .BTN1A(BTN1A), .BTN3A(BTN3A), .BTN1B(BTN1B), .BTN3B(BTN3B),
      .OKA(OKA), .OKB(OKB), .LivA(LivA), .LivB(LivB),
      .LDR1A(LDR1A), .LDR2A(LDR2A), .LDR1B(LDR1B), .LDR2B(LDR2B), .STA(STA), .STB(STB),
      .game_clr(game_clr), .DispA(DispA), .DispB(DispB), .winner(winner), .turn_cnt(turn_cnt)
   );

   battleship_turn_ctrl #(.SETTLE_CYC(S), .TURN_W(2), .DISP_W(3)) dut2 (
      .clk(clk), .clr(clr), .BTN1A(BTN1A), .BTN3A(BTN3A), .BTN1B(BTN1B), .BTN3B(BTN3B),
      .OKA(OKA), .OKB(OKB), .LivA(LivA), .LivB(LivB),
      .LDR1A(LDR1A2), .LDR2A(LDR2A2), .LDR1B(LDR1B2), .LDR2B(LDR2B2), .STA(STA2), .STB(STB2),
      .game_clr(game_clr2), .DispA(DispA2), .DispB(DispB2), .winner(winner2),
      .turn_cnt(turn_cnt2)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic int expDispA();
      case (mPhase)
         0:       return 0;
         1:       return 1;
         2:       return mTurnA ? 2 : 1;
         default: return (mWinner == 1) ? 3 : 4;
      endcase
   endfunction

   function automatic int expDispB();
      case (mPhase)
         0:       return 1;
         1:       return 0;
         2:       return mTurnA ? 1 : 2;
         default: return (mWinner == 2) ? 3 : 4;
      endcase
   endfunction

   function automatic int sat(input int v, input int mx);
      return (v > mx) ? mx : v;
   endfunction

   // Quiescent-state check of both instances against the model
   task automatic checkIdle(input string tag);
      checkOutput({tag, ".strobes"}, 32'(strobes), 0);
      checkOutput({tag, ".dispA"}, 32'(DispA), expDispA());
      checkOutput({tag, ".dispB"}, 32'(DispB), expDispB());
      checkOutput({tag, ".winner"}, 32'(winner), mWinner);
      checkOutput({tag, ".turns"}, 32'(turn_cnt), sat(mTurns, 255));
      checkOutput({tag, ".gclr"}, 32'(game_clr), 0);
      checkOutput({tag, ".strobes2"}, 32'(strobes2), 0);
      checkOutput({tag, ".dispA2"}, 32'(DispA2), expDispA());
      checkOutput({tag, ".dispB2"}, 32'(DispB2), expDispB());
      checkOutput({tag, ".winner2"}, 32'(winner2), mWinner);
      checkOutput({tag, ".turns2"}, 32'(turn_cnt2), sat(mTurns, 3));
      checkOutput({tag, ".gclr2"}, 32'(game_clr2), 0);
   endtask

   task automatic modelNewGame();
      mPhase  = 0;
      mTurnA  = 1'b1;
      mWinner = 0;
      mTurns  = 0;
   endtask

   // Confirm a placement; liv is what the fleet-alive line shows once the register is loaded
   task automatic applyStimulus_place(input bit isA, input bit liv);
      if (isA) BTN1A = 1'b1; else BTN1B = 1'b1;
      tick();
      checkOutput("place.pulse", 32'(strobes), 0);
      tick();
      checkOutput("place.load", 32'(strobes), isA ? 6'b100000 : 6'b001000);
      BTN1A = 1'b0;
      BTN1B = 1'b0;
      tick();
      if (isA) LivA = liv; else LivB = liv;
      checkOutput("place.chk", 32'(strobes), 0);
      repeat (S) tick();
      if (liv) begin
         mPhase = isA ? 1 : 2;
         mTurnA = 1'b1;
      end
      checkIdle(isA ? "placeA" : "placeB");
   endtask

   // One attack attempt by the player on turn
   task automatic applyStimulus_fire(input bit ok, input bit hit, input bit otherPress,
                                     input bit ownBtn3);
      bit atkA;
      atkA = mTurnA;
      if (atkA) begin
         BTN1A = 1'b1; OKB = ok;
         if (otherPress) BTN1B = 1'b1;
         if (ownBtn3) BTN3A = 1'b1;
      end else begin
         BTN1B = 1'b1; OKA = ok;
         if (otherPress) BTN1A = 1'b1;
         if (ownBtn3) BTN3B = 1'b1;
      end
      tick();
      checkOutput("fire.pulse", 32'(strobes), 0);
      tick();
      checkOutput("fire.ldr2", 32'(strobes), !ok ? 6'b000000 : (atkA ? 6'b010000 : 6'b000100));
      BTN1A = 1'b0; BTN1B = 1'b0; BTN3A = 1'b0; BTN3B = 1'b0; OKA = 1'b0; OKB = 1'b0;
      if (!ok) begin
         tick();
         checkIdle("fire.ignored");
         return;
      end
      tick();
      checkOutput("fire.hit", 32'(strobes), atkA ? 6'b001001 : 6'b100010);
      if (hit) begin
         if (atkA) fleetB--; else fleetA--;
      end
      tick();
      if (atkA) LivB = (fleetB > 0); else LivA = (fleetA > 0);
      checkOutput("fire.settle", 32'(strobes), 0);
      repeat (S) tick();
      if ((atkA ? fleetB : fleetA) == 0) begin
         mPhase  = 3;
         mWinner = atkA ? 1 : 2;
      end else begin
         mTurns++;
         mTurnA = !atkA;
      end
      checkIdle(atkA ? "fireA" : "fireB");
   endtask

   // New game from OVER (one player) or an abort (both new-game buttons together)
   task automatic applyStimulus_restart(input bit viaA, input bit both);
      BTN3A = viaA | both;
      BTN3B = !viaA | both;
      tick();
      tick();
      checkOutput("restart.gclr", 32'(game_clr), 1);
      checkOutput("restart.strobes", 32'(strobes), 0);
      BTN3A = 1'b0;
      BTN3B = 1'b0;
      tick();
      modelNewGame();
      checkIdle("restart");
   endtask

   initial begin
      int cntA;
      int cntB;
      int cntS;
      clr = 1'b1;
      BTN1A = 1'b0; BTN3A = 1'b0; BTN1B = 1'b0; BTN3B = 1'b0;
      OKA = 1'b0; OKB = 1'b0; LivA = 1'b0; LivB = 1'b0;
      modelNewGame();

      tick();
      tick();
      checkOutput("reset.gclr", 32'(game_clr), 1);
      checkOutput("reset.strobes", 32'(strobes), 0);
      checkOutput("reset.dispA", 32'(DispA), 0);
      checkOutput("reset.dispB", 32'(DispB), 1);
      checkOutput("reset.winner", 32'(winner), 0);
      checkOutput("reset.turns", 32'(turn_cnt), 0);
      clr = 1'b0;
      tick();
      checkIdle("reset.release");

      // Held confirm with an empty fleet: exactly one load, rejected back to PLACE_A
      cntA = 0; cntB = 0; cntS = 0;
      BTN1A = 1'b1;
      for (int c = 0; c < 20; c++) begin
         tick();
         if (LDR1A) cntA++;
         if (LDR1B) cntB++;
         if (STA) cntS++;
      end
      BTN1A = 1'b0;
      repeat (3) tick();
      checkOutput("held.ldr1a", 32'(cntA), 1);
      checkOutput("held.ldr1b", 32'(cntB), 0);
      checkOutput("held.sta", 32'(cntS), 0);
      checkIdle("held.reject");

      fleetA = 3;
      fleetB = 3;
      applyStimulus_place(1'b1, 1'b1);
      applyStimulus_place(1'b0, 1'b0);
      applyStimulus_place(1'b0, 1'b1);

      applyStimulus_fire(1'b0, 1'b0, 1'b0, 1'b0);
      applyStimulus_fire(1'b1, 1'b0, 1'b0, 1'b1);
      applyStimulus_fire(1'b1, 1'b1, 1'b1, 1'b0);
      for (int t = 0; t < 3; t++) applyStimulus_fire(1'b1, 1'b0, 1'b0, 1'b0);
      checkOutput("sat.turns8", 32'(turn_cnt), 5);
      checkOutput("sat.turns2", 32'(turn_cnt2), 3);

      // A sinks B's fleet while B keeps missing
      for (int t = 0; t < 20 && mPhase == 2; t++) applyStimulus_fire(1'b1, mTurnA, 1'b0, 1'b0);
      checkOutput("win.winner", 32'(winner), 1);
      checkOutput("win.dispA", 32'(DispA), 3);
      checkOutput("win.dispB", 32'(DispB), 4);
      applyStimulus_restart(1'b0, 1'b0);

      // Reset in the middle of A's hit transfer
      fleetA = 2;
      fleetB = 2;
      applyStimulus_place(1'b1, 1'b1);
      applyStimulus_place(1'b0, 1'b1);
      BTN1A = 1'b1;
      OKB   = 1'b1;
      tick();
      tick();
      BTN1A = 1'b0;
      OKB   = 1'b0;
      tick();
      checkOutput("midclr.hit", 32'(strobes), 6'b001001);
      clr = 1'b1;
      tick();
      checkOutput("midclr.strobes", 32'(strobes), 0);
      checkOutput("midclr.gclr", 32'(game_clr), 1);
      checkOutput("midclr.dispA", 32'(DispA), 0);
      checkOutput("midclr.dispB", 32'(DispB), 1);
      clr = 1'b0;
      tick();
      modelNewGame();
      checkIdle("midclr.after");

      // Abort mid-game
      applyStimulus_place(1'b1, 1'b1);
      applyStimulus_place(1'b0, 1'b1);
      applyStimulus_fire(1'b1, 1'b0, 1'b0, 1'b0);
      applyStimulus_restart(1'b0, 1'b1);

      for (int g = 0; g < 4; g++) begin
         fleetA = $urandom_range(1, 3);
         fleetB = $urandom_range(1, 3);
         if ($urandom_range(0, 2) == 0) applyStimulus_place(1'b1, 1'b0);
         applyStimulus_place(1'b1, 1'b1);
         if ($urandom_range(0, 2) == 0) applyStimulus_place(1'b0, 1'b0);
         applyStimulus_place(1'b0, 1'b1);
         for (int m = 0; m < 40 && mPhase == 2; m++) begin
            applyStimulus_fire($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         end
         if (mPhase == 3) applyStimulus_restart(1'($urandom_range(0, 1)), 1'b0);
         else applyStimulus_restart(1'b0, 1'b1);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
